// File: rtl/counter_pkg.sv
// Shared encodings for the quadrature decoder: phase words, prime FSM
// states, direction values and the transition classifier.
package counter_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [1:0] {
        PRIME0,
        PRIME1,
        PRIME2,
        TRACK
    } prime_state_t;

    typedef enum logic [1:0] {
        MV_NONE,
        MV_FWD,
        MV_REV,
        MV_ILL
    } move_t;

    // Classify one sampled phase transition; anything not one Gray step is illegal.
    function automatic move_t decode_move(
        input logic [1:0] prev,
        input logic [1:0] ph
    );
        move_t mv;
        mv = MV_ILL;
        case ({prev, ph})
            {PH_00, PH_00},
            {PH_01, PH_01},
            {PH_11, PH_11},
            {PH_10, PH_10}: mv = MV_NONE;
            {PH_00, PH_01},
            {PH_01, PH_11},
            {PH_11, PH_10},
            {PH_10, PH_00}: mv = MV_FWD;
            {PH_00, PH_10},
            {PH_10, PH_11},
            {PH_11, PH_01},
            {PH_01, PH_00}: mv = MV_REV;
            default:        mv = MV_ILL;
        endcase
        return mv;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
// Both stages reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;
    logic meta_d;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: synchronizes the phases, primes a reference,
// then emits step/dir/err pulses and keeps a wrapping position count.
module quadrature_decoder
    import counter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enc_a,
    input  logic         enc_b,
    input  logic         clear,
    output logic [N-1:0] count,
    output logic         dir,
    output logic         step,
    output logic         err,
    output logic         err_flag
);

    localparam logic [N-1:0] ONE = N'(1);

    logic a_s;
    logic b_s;
    logic [1:0] ph;
    move_t mv;

    prime_state_t state_q, state_d;
    logic [1:0]   prev_q, prev_d;
    logic [N-1:0] count_q, count_d;
    logic         dir_q, dir_d;
    logic         step_q, step_d;
    logic         err_q, err_d;
    logic         err_flag_q, err_flag_d;

    sync_2ff u_sync_a (
        .clk   (clk),
        .reset (reset),
        .d     (enc_a),
        .q     (a_s)
    );

    sync_2ff u_sync_b (
        .clk   (clk),
        .reset (reset),
        .d     (enc_b),
        .q     (b_s)
    );

    assign ph = {a_s, b_s};
    assign mv = decode_move(prev_q, ph);

    always_comb begin
        state_d    = state_q;
        prev_d     = ph;
        count_d    = count_q;
        dir_d      = dir_q;
        step_d     = 1'b0;
        err_d      = 1'b0;
        err_flag_d = err_flag_q;

        case (state_q)
            PRIME0:  state_d = PRIME1;
            PRIME1:  state_d = PRIME2;
            PRIME2:  state_d = TRACK;
            default: state_d = TRACK;
        endcase

        if (state_q == TRACK) begin
            case (mv)
                MV_FWD: begin
                    count_d = count_q + ONE;
                    dir_d   = DIR_UP;
                    step_d  = 1'b1;
                end
                MV_REV: begin
                    count_d = count_q - ONE;
                    dir_d   = DIR_DN;
                    step_d  = 1'b1;
                end
                MV_ILL: begin
                    err_d      = 1'b1;
                    err_flag_d = 1'b1;
                end
                default: ;
            endcase
        end

        // clear beats a same-cycle step, but a same-cycle error still sticks
        if (clear) begin
            count_d    = '0;
            err_flag_d = err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PRIME0;
            prev_q     <= PH_00;
            count_q    <= '0;
            dir_q      <= DIR_UP;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            err_q      <= err_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign count    = count_q;
    assign dir      = dir_q;
    assign step     = step_q;
    assign err      = err_q;
    assign err_flag = err_flag_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Randomized bench for quadrature_decoder against a position-index model.
// Phases move every 4 clocks; results are sampled 1 ns after rising edges.
module tb_quadrature_decoder;

    localparam int N = 4;
    localparam int MOD = 1 << N;

    logic         clk;
    logic         reset;
    logic         enc_a;
    logic         enc_b;
    logic         clear;
    logic [N-1:0] count;
    logic         dir;
    logic         step;
    logic         err;
    logic         err_flag;

    int total;
    int bad;

    int m_count;
    int m_dir;
    int m_flag;
    logic [1:0] m_prev;

    int g_steps;
    int g_errs;

    quadrature_decoder #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .clear    (clear),
        .count    (count),
        .dir      (dir),
        .step     (step),
        .err      (err),
        .err_flag (err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Position of a phase word around the cycle 00,01,11,10.
    function automatic int gidx(input logic [1:0] p);
        return {30'd0, p[1], p[1] ^ p[0]};
    endfunction

    function automatic logic [1:0] gray(input int i);
        logic [1:0] b;
        b = 2'(i & 3);
        return {b[1], b[1] ^ b[0]};
    endfunction

    function automatic logic [1:0] nxt(input logic [1:0] p, input bit up);
        return gray(gidx(p) + (up ? 1 : 3));
    endfunction

    task automatic move(input logic [1:0] ab, input bit do_clr);
        int d;
        int ns;
        int ne;
        int first;
        int exp_s;
        int exp_e;
        d = (gidx(ab) - gidx(m_prev)) & 3;
        exp_s = (d == 1 || d == 3) ? 1 : 0;
        exp_e = (d == 2) ? 1 : 0;
        ns = 0;
        ne = 0;
        first = 0;
        @(negedge clk);
        enc_a = ab[1];
        enc_b = ab[0];
        for (int i = 1; i <= 4; i++) begin
            if (do_clr && i == 3) clear = 1'b1;
            @(posedge clk);
            #1;
            clear = 1'b0;
            if (step) begin
                ns++;
                if (first == 0) first = i;
            end
            if (err) begin
                ne++;
                if (first == 0) first = i;
            end
            check("step_err_excl", int'(step & err), 0);
        end
        if (d == 1) begin
            m_count = (m_count + 1) % MOD;
            m_dir = 1;
        end else if (d == 3) begin
            m_count = (m_count + MOD - 1) % MOD;
            m_dir = 0;
        end else if (d == 2) begin
            m_flag = 1;
        end
        if (do_clr) begin
            m_count = 0;
            m_flag = exp_e;
        end
        m_prev = ab;
        g_steps += ns;
        g_errs += ne;
        check("step_pulses", ns, exp_s);
        check("err_pulses", ne, exp_e);
        if (exp_s + exp_e > 0) check("latency", first, 3);
        check("count", int'(count), m_count);
        check("dir", int'(dir), m_dir);
        check("err_flag", int'(err_flag), m_flag);
    endtask

    task automatic do_reset(input logic [1:0] ab);
        int pulses;
        @(negedge clk);
        reset = 1'b1;
        enc_a = ab[1];
        enc_b = ab[0];
        clear = 1'b0;
        #2;
        check("rst_count", int'(count), 0);
        check("rst_dir", int'(dir), 1);
        check("rst_step", int'(step), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_flag", int'(err_flag), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_count = 0;
        m_dir = 1;
        m_flag = 0;
        m_prev = ab;
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            pulses += int'(step) + int'(err);
        end
        check("prime_quiet", pulses, 0);
        check("prime_count", int'(count), 0);
    endtask

    initial begin
        int s0;
        int e0;
        int r;
        logic [1:0] p;
        total = 0;
        bad = 0;
        g_steps = 0;
        g_errs = 0;
        reset = 1'b1;
        clear = 1'b0;
        enc_a = 1'($urandom);
        enc_b = 1'($urandom);
        m_prev = 2'b00;

        // 1: reset with arbitrary pins, then release with AB=00
        r = $urandom_range(0, 3);
        p = 2'(r);
        @(negedge clk);
        enc_a = p[1];
        enc_b = p[0];
        #1;
        check("rst0_count", int'(count), 0);
        check("rst0_dir", int'(dir), 1);
        do_reset(2'b00);

        // 2: forward 00->01->11->10->00->01
        s0 = g_steps;
        move(2'b01, 0);
        move(2'b11, 0);
        move(2'b10, 0);
        move(2'b00, 0);
        move(2'b01, 0);
        check("t2_steps", g_steps - s0, 5);
        check("t2_count", int'(count), 5);
        check("t2_dir", int'(dir), 1);

        // 3: reverse 01->00->10->11
        s0 = g_steps;
        move(2'b00, 0);
        move(2'b10, 0);
        move(2'b11, 0);
        check("t3_steps", g_steps - s0, 3);
        check("t3_count", int'(count), 2);
        check("t3_dir", int'(dir), 0);

        // 4: clear, 15 forward, wrap up, wrap down
        move(m_prev, 1);
        check("t4_clr", int'(count), 0);
        for (int i = 0; i < 15; i++) move(nxt(m_prev, 1), 0);
        check("t4_15", int'(count), 15);
        move(nxt(m_prev, 1), 0);
        check("t4_wrap_up", int'(count), 0);
        move(nxt(m_prev, 0), 0);
        check("t4_wrap_dn", int'(count), 15);

        // 5: illegal jump, then clear
        e0 = g_errs;
        move(m_prev ^ 2'b11, 0);
        check("t5_errs", g_errs - e0, 1);
        check("t5_flag", int'(err_flag), 1);
        check("t5_count", int'(count), 15);
        check("t5_dir", int'(dir), 0);
        move(m_prev, 1);
        check("t5_clr_flag", int'(err_flag), 0);
        check("t5_clr_count", int'(count), 0);

        // 6: reset mid-count with AB held at 11
        move(nxt(m_prev, 1), 0);
        move(nxt(m_prev, 1), 0);
        if (m_prev != 2'b11) move(2'b11, 0);
        do_reset(2'b11);
        move(2'b10, 0);
        check("t6_count", int'(count), 1);
        check("t6_dir", int'(dir), 1);
        s0 = g_steps;
        move(nxt(m_prev, 1), 1);
        check("t6_clr_step", g_steps - s0, 1);
        check("t6_clr_count", int'(count), 0);

        // randomized walk
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) p = m_prev;
            else if (r == 1) p = m_prev ^ 2'b11;
            else p = nxt(m_prev, 1'($urandom));
            move(p, $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
